// File: rtl/debug_pkg.sv
// debug_pkg: shared constants and types
// for the debug command parser.
package debug_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] ACK_BYTE   = 8'h06;
  localparam logic [7:0] NAK_BYTE   = 8'h15;
  localparam logic [6:0] CLEAR_ADDR = 7'h7F;

  localparam int ST_BAD = 0;
  localparam int ST_TMO = 1;
  localparam int ST_OVR = 2;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

endpackage

// File: rtl/gap_timer.sv
// gap_timer: saturating inter-byte gap counter
// with a one-cycle expire pulse at TC-1.
module gap_timer #(
  parameter int TC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (TC > 1) ? $clog2(TC) : 1;
  localparam logic [W-1:0] LAST = W'(TC - 1);

  logic [W-1:0] cnt;

  // count while enabled, restart on byte, hold at LAST
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (enable && cnt != LAST)
      cnt <= cnt + W'(1);
  end

  // a byte in the same cycle wins over the timeout
  assign expire = enable && !clear && cnt == LAST;

endmodule

// File: rtl/debug_cmd_parser.sv
// debug_cmd_parser: framed register read/write
// decoder with a one-entry response register.
module debug_cmd_parser
  import debug_pkg::*;
#(
  parameter int NREGS          = 4,
  parameter int TIMEOUT_CYCLES = 250000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_rx_byte,
  input  logic               i_rx_ready,
  output logic [8*NREGS-1:0] o_regs,
  output logic [7:0]         o_tx_byte,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic [2:0]         o_status
);

  state_t             state;
  logic [6:0]         cmd_addr;
  logic [8*NREGS-1:0] bank;

  logic       expire;
  logic       hs;
  logic       resp_new;
  logic [7:0] resp_byte;
  logic       wr_en;
  logic       clr_st;
  logic [2:0] set_st;
  logic [6:0] addr;
  logic       in_range;

  gap_timer #(
    .TC(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (i_clk),
    .rst   (i_rst),
    .clear (i_rx_ready),
    .enable(state != IDLE),
    .expire(expire)
  );

  assign hs     = o_tx_valid && i_tx_ready;
  assign o_regs = bank;

  // decode the byte completing a frame into a response
  always_comb begin
    resp_new  = 1'b0;
    resp_byte = 8'h00;
    wr_en     = 1'b0;
    clr_st    = 1'b0;
    set_st    = 3'b000;
    addr      = (state == DATA) ? cmd_addr
                                : i_rx_byte[6:0];
    in_range  = 32'(addr) < NREGS;
    if (i_rx_ready) begin
      unique case (state)
        CMD: begin
          if (!i_rx_byte[7]) begin
            resp_new = 1'b1;
            if (addr == CLEAR_ADDR) begin
              clr_st    = 1'b1;
              resp_byte = ACK_BYTE;
            end else if (in_range) begin
              for (int i = 0; i < NREGS; i++)
                if (addr == 7'(i))
                  resp_byte = bank[8*i +: 8];
            end else begin
              resp_byte      = NAK_BYTE;
              set_st[ST_BAD] = 1'b1;
            end
          end
        end
        DATA: begin
          resp_new = 1'b1;
          if (addr == CLEAR_ADDR) begin
            clr_st    = 1'b1;
            resp_byte = ACK_BYTE;
          end else if (in_range) begin
            wr_en     = 1'b1;
            resp_byte = ACK_BYTE;
          end else begin
            resp_byte      = NAK_BYTE;
            set_st[ST_BAD] = 1'b1;
          end
        end
        default: ;
      endcase
    end
    set_st[ST_TMO] = expire;
    set_st[ST_OVR] = resp_new && o_tx_valid && !hs;
  end

  // frame FSM, response register and sticky status
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      cmd_addr   <= '0;
      o_tx_byte  <= '0;
      o_tx_valid <= 1'b0;
      o_status   <= '0;
    end else begin
      unique case (state)
        IDLE:
          if (i_rx_ready && i_rx_byte == SYNC_BYTE)
            state <= CMD;
        CMD:
          if (i_rx_ready) begin
            cmd_addr <= i_rx_byte[6:0];
            state    <= i_rx_byte[7] ? DATA : IDLE;
          end else if (expire) begin
            state <= IDLE;
          end
        DATA:
          if (i_rx_ready || expire)
            state <= IDLE;
        default: state <= IDLE;
      endcase

      if (resp_new && (!o_tx_valid || hs)) begin
        o_tx_byte  <= resp_byte;
        o_tx_valid <= 1'b1;
      end else if (hs) begin
        o_tx_valid <= 1'b0;
      end

      if (clr_st)
        o_status <= set_st;
      else
        o_status <= o_status | set_st;
    end
  end

  // register bank: written by a completed write frame
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bank <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NREGS; i++)
        if (cmd_addr == 7'(i))
          bank[8*i +: 8] <= i_rx_byte;
    end
  end

endmodule

// File: tb/tb_debug_cmd_parser.sv
// tb_debug_cmd_parser: directed vectors with
// hand-computed expectations.
module tb_debug_cmd_parser;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic [31:0] regs;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [2:0]  status;

  int n_cmp = 0;
  int n_err = 0;

  debug_cmd_parser #(
    .NREGS(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_rx_byte (rx_byte),
    .i_rx_ready(rx_ready),
    .o_regs    (regs),
    .o_tx_byte (tx_byte),
    .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready),
    .o_status  (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_ready = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic drain();
    tx_ready = 1'b1;
    idle();
    check("drain_valid", 32'(tx_valid), 0);
    tx_ready = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    rx_byte  = 8'h00;
    rx_ready = 1'b0;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_regs", regs, 32'h0);
    check("rst_valid", 32'(tx_valid), 0);
    check("rst_byte", 32'(tx_byte), 0);
    check("rst_status", 32'(status), 0);

    // write reg1
    strobe(8'hA5); strobe(8'h81); strobe(8'h3C);
    idle();
    check("wr_regs", regs, 32'h0000_3C00);
    check("wr_valid", 32'(tx_valid), 1);
    check("wr_byte", 32'(tx_byte), 32'h06);
    drain();

    // preload reg2, then read it
    strobe(8'hA5); strobe(8'h82); strobe(8'h5A);
    idle();
    check("pre_regs", regs, 32'h005A_3C00);
    drain();
    tx_ready = 1'b1;
    strobe(8'hA5); strobe(8'h02);
    idle();
    check("rd_valid", 32'(tx_valid), 1);
    check("rd_byte", 32'(tx_byte), 32'h5A);
    idle();
    check("rd_valid_fall", 32'(tx_valid), 0);
    tx_ready = 1'b0;

    // bad address, then clear
    strobe(8'hA5); strobe(8'h85); strobe(8'h11);
    idle();
    check("bad_byte", 32'(tx_byte), 32'h15);
    check("bad_status", 32'(status), 32'b001);
    check("bad_regs", regs, 32'h005A_3C00);
    drain();
    strobe(8'hA5); strobe(8'hFF); strobe(8'h00);
    idle();
    check("clr_byte", 32'(tx_byte), 32'h06);
    check("clr_status", 32'(status), 0);
    check("clr_regs", regs, 32'h005A_3C00);
    drain();

    // timeout: 16 empty cycles inside a frame
    strobe(8'hA5); strobe(8'h81);
    repeat (16) idle();
    check("tmo_early", 32'(status), 0);
    idle();
    check("tmo_status", 32'(status), 32'b010);
    check("tmo_valid", 32'(tx_valid), 0);
    strobe(8'h3C);
    idle();
    check("tmo_regs", regs, 32'h005A_3C00);
    check("tmo_no_resp", 32'(tx_valid), 0);

    // byte on the expiry cycle beats the timeout
    strobe(8'hA5); strobe(8'hFF); strobe(8'h00);
    idle();
    check("clr2_status", 32'(status), 0);
    drain();
    strobe(8'hA5); strobe(8'h81);
    repeat (15) idle();
    strobe(8'h7E);
    idle();
    check("sup_regs", regs, 32'h005A_7E00);
    check("sup_status", 32'(status), 0);
    check("sup_byte", 32'(tx_byte), 32'h06);
    drain();

    // overrun: two reads while tx is stalled
    strobe(8'hA5); strobe(8'h01);
    strobe(8'hA5); strobe(8'h02);
    idle();
    check("ovr_byte", 32'(tx_byte), 32'h7E);
    check("ovr_valid", 32'(tx_valid), 1);
    check("ovr_status", 32'(status), 32'b100);
    tx_ready = 1'b1;
    idle();
    check("ovr_fall", 32'(tx_valid), 0);
    tx_ready = 1'b0;

    // reset in the middle of a frame
    strobe(8'hA5); strobe(8'h81);
    @(negedge clk);
    rx_ready = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    strobe(8'h3C);
    idle();
    check("mrst_regs", regs, 32'h0);
    check("mrst_valid", 32'(tx_valid), 0);
    check("mrst_byte", 32'(tx_byte), 0);
    check("mrst_status", 32'(status), 0);
    strobe(8'hA5); strobe(8'h81); strobe(8'h3C);
    idle();
    check("mrst_wr_regs", regs, 32'h0000_3C00);
    check("mrst_wr_byte", 32'(tx_byte), 32'h06);
    check("mrst_wr_valid", 32'(tx_valid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
